// File: rtl/gray_step_sched_if.sv
// Handshake bundle between the requesters, the burst scheduler and the shared Gray counter.
// The master side is the requester/counter environment; the slave side is the scheduler.
interface gray_step_sched_if #(
    parameter int N_REQ = 4,
    parameter int LEN_W = 4
);
    logic [N_REQ-1:0]       Req;
    logic [N_REQ*LEN_W-1:0] Len;
    logic [N_REQ-1:0]       Grant;
    logic [N_REQ-1:0]       Done;
    logic                   OvfFlag;
    logic                   CntEn;
    logic                   CntOvf;
    logic                   Busy;

    modport master (
        output Req, Len, CntOvf,
        input  Grant, Done, OvfFlag, CntEn, Busy
    );

    modport slave (
        input  Req, Len, CntOvf,
        output Grant, Done, OvfFlag, CntEn, Busy
    );
endinterface

// File: rtl/gray_step_sched.sv
// Round-robin burst scheduler sharing one 3-bit Gray counter: grants one requester at a time,
// enables the counter for exactly Len cycles and reports completion with a wrap flag.
//
// state | meaning
// IDLE  | no burst in flight; arbitrate among Req from rr_ptr+1
// RUN   | CntEn high, rem counting down to the last enabled cycle
// DONE  | one-cycle Done pulse to the granted requester, Grant still held
module gray_step_sched #(
    parameter int N_REQ = 4,
    parameter int LEN_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    gray_step_sched_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state,    state_n;
    logic [N_REQ-1:0] grant,    grant_n;
    logic [IDX_W-1:0] rr_ptr,   rr_ptr_n;
    logic [LEN_W-1:0] rem,      rem_n;
    logic             cnt_en,   cnt_en_n;
    logic             ovf_s,    ovf_s_n;
    logic             first,    first_n;
    logic             zero_len, zero_len_n;

    logic             pick_valid;
    logic [IDX_W-1:0] pick;
    logic [LEN_W-1:0] len_arr [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            len_arr[i] = bus.Len[i*LEN_W +: LEN_W];
        end
    end

    // Scan downwards so the closest requester after rr_ptr is the last one written.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (bus.Req[IDX_W'((int'(rr_ptr) + k) % N_REQ)]) begin
                pick_valid = 1'b1;
                pick       = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= IDX_W'(N_REQ - 1);
            rem      <= '0;
            cnt_en   <= 1'b0;
            ovf_s    <= 1'b0;
            first    <= 1'b0;
            zero_len <= 1'b0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            rr_ptr   <= rr_ptr_n;
            rem      <= rem_n;
            cnt_en   <= cnt_en_n;
            ovf_s    <= ovf_s_n;
            first    <= first_n;
            zero_len <= zero_len_n;
        end
    end

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        rr_ptr_n   = rr_ptr;
        rem_n      = rem;
        cnt_en_n   = cnt_en;
        ovf_s_n    = ovf_s;
        first_n    = first;
        zero_len_n = zero_len;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    rr_ptr_n      = pick;
                    rem_n         = len_arr[pick];
                    if (len_arr[pick] != '0) begin
                        state_n    = RUN;
                        cnt_en_n   = 1'b1;
                        ovf_s_n    = 1'b0;
                        first_n    = 1'b1;
                        zero_len_n = 1'b0;
                    end else begin
                        state_n    = DONE;
                        cnt_en_n   = 1'b0;
                        zero_len_n = 1'b1;
                    end
                end
            end
            RUN: begin
                // CntOvf in the first RUN cycle still reflects the previous burst.
                first_n = 1'b0;
                if (!first) begin
                    ovf_s_n = ovf_s | bus.CntOvf;
                end
                rem_n = rem - 1'b1;
                if (rem == LEN_W'(1)) begin
                    state_n  = DONE;
                    cnt_en_n = 1'b0;
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
            end
            default: begin
                state_n  = IDLE;
                grant_n  = '0;
                cnt_en_n = 1'b0;
            end
        endcase
    end

    assign bus.Grant   = grant;
    assign bus.CntEn   = cnt_en;
    assign bus.Busy    = (state == RUN) || (state == DONE);
    assign bus.Done    = (state == DONE) ? grant : '0;
    // The last enable's wrap only shows up on CntOvf during DONE itself.
    assign bus.OvfFlag = (state == DONE) && !zero_len && (ovf_s || bus.CntOvf);
endmodule

// File: tb/tb_gray_step_sched.sv
// Directed bench for gray_step_sched with a behavioural 3-bit Gray counter on CntEn/CntOvf.
module tb_gray_step_sched;
    logic       clk = 1'b0;
    logic       reset;
    logic       cnt_clr;
    logic [2:0] cnt_bin;
    logic       cnt_ovf;
    logic [2:0] gray;
    int         checks = 0;
    int         errors = 0;
    int         order [5] = '{0, 1, 2, 3, 0};

    gray_step_sched_if #(.N_REQ(4), .LEN_W(4)) bus ();

    gray_step_sched #(.N_REQ(4), .LEN_W(4)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Counter model: overflow is registered and only updates on enabled edges.
    always @(posedge clk) begin
        if (cnt_clr) begin
            cnt_bin <= 3'd0;
            cnt_ovf <= 1'b0;
        end else if (bus.CntEn) begin
            cnt_bin <= cnt_bin + 3'd1;
            cnt_ovf <= (cnt_bin == 3'd7);
        end
    end

    assign bus.CntOvf = cnt_ovf;
    assign gray       = cnt_bin ^ (cnt_bin >> 1);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b0;
        cnt_clr = 1'b1;
        bus.Req = 4'b1111;
        bus.Len = 16'h1111;

        // reset holds everything idle even with all requests up
        step();
        step();
        chk("rst_grant",   32'(bus.Grant),   32'h0);
        chk("rst_cnten",   32'(bus.CntEn),   32'h0);
        chk("rst_done",    32'(bus.Done),    32'h0);
        chk("rst_busy",    32'(bus.Busy),    32'h0);
        chk("rst_ovfflag", 32'(bus.OvfFlag), 32'h0);

        reset   = 1'b1;
        cnt_clr = 1'b0;
        bus.Req = 4'b0000;
        step();
        chk("idle_busy", 32'(bus.Busy), 32'h0);

        // requester 1, Len=3; Len changed after grant must be ignored
        bus.Req = 4'b0010;
        bus.Len = 16'h0030;
        step();
        chk("t2_grant", 32'(bus.Grant), 32'h2);
        chk("t2_en1",   32'(bus.CntEn), 32'h1);
        chk("t2_busy",  32'(bus.Busy),  32'h1);
        chk("t2_nodone", 32'(bus.Done), 32'h0);
        bus.Len = 16'h00F0;
        step();
        chk("t2_en2", 32'(bus.CntEn), 32'h1);
        step();
        chk("t2_en3", 32'(bus.CntEn), 32'h1);
        step();
        chk("t2_en_off", 32'(bus.CntEn),   32'h0);
        chk("t2_done",   32'(bus.Done),    32'h2);
        chk("t2_grant_held", 32'(bus.Grant), 32'h2);
        chk("t2_ovf",    32'(bus.OvfFlag), 32'h0);
        chk("t2_gray",   32'(gray),        32'h2);
        bus.Req = 4'b0000;
        step();
        chk("t2_idle_grant", 32'(bus.Grant), 32'h0);
        chk("t2_idle_done",  32'(bus.Done),  32'h0);
        chk("t2_idle_busy",  32'(bus.Busy),  32'h0);

        // requester 0, Len=8 from counter 0 wraps exactly on the last enable
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        bus.Req = 4'b0001;
        bus.Len = 16'h0008;
        step();
        chk("t3_grant", 32'(bus.Grant), 32'h1);
        chk("t3_en1",   32'(bus.CntEn), 32'h1);
        for (int i = 2; i <= 8; i++) begin
            step();
            chk("t3_en", 32'(bus.CntEn), 32'h1);
        end
        step();
        chk("t3_en_off", 32'(bus.CntEn),   32'h0);
        chk("t3_done",   32'(bus.Done),    32'h1);
        chk("t3_ovf",    32'(bus.OvfFlag), 32'h1);
        chk("t3_gray",   32'(gray),        32'h0);
        bus.Req = 4'b0000;
        step();

        // requester 2, Len=2 starting with stale CntOvf=1: no wrap, flag must stay low
        bus.Req = 4'b0100;
        bus.Len = 16'h0200;
        step();
        chk("t3c_grant", 32'(bus.Grant), 32'h4);
        step();
        chk("t3c_en2", 32'(bus.CntEn), 32'h1);
        step();
        chk("t3c_done", 32'(bus.Done),    32'h4);
        chk("t3c_ovf",  32'(bus.OvfFlag), 32'h0);
        bus.Req = 4'b0000;
        step();

        // requester 3, Len=10 from count 2: wrap mid-burst must be remembered at DONE
        bus.Req = 4'b1000;
        bus.Len = 16'hA000;
        step();
        chk("t3b_grant", 32'(bus.Grant), 32'h8);
        for (int i = 2; i <= 10; i++) begin
            step();
            chk("t3b_en", 32'(bus.CntEn), 32'h1);
        end
        step();
        chk("t3b_done",      32'(bus.Done),    32'h8);
        chk("t3b_cntovf_lo", 32'(bus.CntOvf),  32'h0);
        chk("t3b_ovf",       32'(bus.OvfFlag), 32'h1);
        chk("t3b_gray",      32'(gray),        32'h6);
        bus.Req = 4'b0000;
        step();

        // all four requesting with Len=1: rotation 0,1,2,3,0, three cycles per burst
        bus.Req = 4'b1111;
        bus.Len = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_grant", 32'(bus.Grant), 32'd1 << order[i]);
            chk("rr_en",    32'(bus.CntEn), 32'h1);
            step();
            chk("rr_done",  32'(bus.Done),  32'd1 << order[i]);
            chk("rr_en_off", 32'(bus.CntEn), 32'h0);
            if (i == 4) bus.Req = 4'b0000;
            step();
            chk("rr_gap", 32'(bus.Grant), 32'h0);
        end

        // requester 2 with Len=0: grant and Done together for one cycle, no enable
        bus.Req = 4'b0100;
        bus.Len = 16'h0000;
        step();
        chk("t5_grant", 32'(bus.Grant),   32'h4);
        chk("t5_done",  32'(bus.Done),    32'h4);
        chk("t5_en",    32'(bus.CntEn),   32'h0);
        chk("t5_ovf",   32'(bus.OvfFlag), 32'h0);
        bus.Req = 4'b0000;
        step();
        chk("t5_grant_off", 32'(bus.Grant), 32'h0);
        chk("t5_done_off",  32'(bus.Done),  32'h0);

        // reset in the 2nd RUN cycle of a Len=5 burst abandons it
        bus.Req = 4'b0010;
        bus.Len = 16'h0050;
        step();
        chk("t6_grant", 32'(bus.Grant), 32'h2);
        step();
        chk("t6_run2", 32'(bus.CntEn), 32'h1);
        reset = 1'b0;
        step();
        chk("t6_rst_grant", 32'(bus.Grant), 32'h0);
        chk("t6_rst_en",    32'(bus.CntEn), 32'h0);
        chk("t6_rst_done",  32'(bus.Done),  32'h0);
        chk("t6_rst_busy",  32'(bus.Busy),  32'h0);
        reset   = 1'b1;
        bus.Req = 4'b0011;
        step();
        chk("t6_restart_grant", 32'(bus.Grant), 32'h1);
        chk("t6_restart_done",  32'(bus.Done),  32'h1);
        bus.Req = 4'b0000;
        step();
        chk("t6_final_idle", 32'(bus.Busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
